// File: rtl/rvsteel_bus_pkg.sv
// Shared types and constants for the multi-manager system bus.
package rvsteel_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } bus_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Unsigned wrap-around makes addresses below the base fall outside the region.
    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] start,
                                        input logic [31:0] size);
        return (addr - start) < size;
    endfunction

endpackage

// File: rtl/rvsteel_rr_arbiter.sv
// Round-robin grant: first requester at or after (last_grant + 1) mod NUM_MANAGERS.
module rvsteel_rr_arbiter #(
    parameter int unsigned NUM_MANAGERS = 2,
    parameter int unsigned IDX_W        = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1
) (
    input  logic [NUM_MANAGERS-1:0] request,
    input  logic [IDX_W-1:0]        last_grant,
    output logic [NUM_MANAGERS-1:0] grant,
    output logic [IDX_W-1:0]        grant_index,
    output logic                    grant_valid
);

    logic [31:0] candidate;

    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        candidate   = '0;
        for (int unsigned i = 0; i < NUM_MANAGERS; i++) begin
            candidate = (32'(last_grant) + 32'd1 + 32'(i)) % 32'(NUM_MANAGERS);
            if (!grant_valid && request[candidate[IDX_W-1:0]]) begin
                grant_valid                     = 1'b1;
                grant_index                     = candidate[IDX_W-1:0];
                grant[candidate[IDX_W-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvsteel_mm_bus.sv
// Multi-manager memory-mapped bus: round-robin arbitration, region decode, access faults.
// Optional ACTIVE-state response timeout enabled by defining RVSTEEL_BUS_TIMEOUT_EN.
module rvsteel_mm_bus
    import rvsteel_bus_pkg::*;
#(
    parameter int unsigned NUM_MANAGERS   = 2,
    parameter int unsigned NUM_DEVICES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MANAGERS*32-1:0] manager_rw_address,
    output logic [NUM_MANAGERS*32-1:0] manager_read_data,
    input  logic [NUM_MANAGERS-1:0]    manager_read_request,
    output logic [NUM_MANAGERS-1:0]    manager_read_response,
    input  logic [NUM_MANAGERS*32-1:0] manager_write_data,
    input  logic [NUM_MANAGERS*4-1:0]  manager_write_strobe,
    input  logic [NUM_MANAGERS-1:0]    manager_write_request,
    output logic [NUM_MANAGERS-1:0]    manager_write_response,
    output logic [NUM_MANAGERS-1:0]    manager_access_fault,
    output logic [31:0]                device_rw_address,
    input  logic [NUM_DEVICES*32-1:0]  device_read_data,
    output logic [NUM_DEVICES-1:0]     device_read_request,
    input  logic [NUM_DEVICES-1:0]     device_read_response,
    output logic [31:0]                device_write_data,
    output logic [3:0]                 device_write_strobe,
    output logic [NUM_DEVICES-1:0]     device_write_request,
    input  logic [NUM_DEVICES-1:0]     device_write_response,
    input  logic [NUM_DEVICES*32-1:0]  device_start_address,
    input  logic [NUM_DEVICES*32-1:0]  device_region_size
);

    localparam int unsigned MGR_IDX_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
    localparam int unsigned DEV_IDX_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

    if (NUM_MANAGERS < 1 || NUM_MANAGERS > 8 || NUM_DEVICES < 1 || NUM_DEVICES > 16 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("rvsteel_mm_bus: parameter out of range");
    end

    bus_state_e           state_q, state_d;
    logic [MGR_IDX_W-1:0] last_grant_q, last_grant_d;
    logic [MGR_IDX_W-1:0] grantee_q, grantee_d;
    logic [DEV_IDX_W-1:0] dev_index_q, dev_index_d;
    logic [31:0]          address_q, address_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           strobe_q, strobe_d;
    logic                 is_write_q, is_write_d;

    logic [NUM_MANAGERS-1:0] arb_grant;
    logic [MGR_IDX_W-1:0]    arb_index;
    logic                    arb_valid;

    logic [31:0]          sel_address, sel_wdata;
    logic [3:0]           sel_strobe;
    logic                 sel_write;
    logic                 dec_hit;
    logic [DEV_IDX_W-1:0] dec_index;
    logic                 dev_resp;
    logic [31:0]          dev_rdata;
    logic                 tmo_expired;

    rvsteel_rr_arbiter #(
        .NUM_MANAGERS (NUM_MANAGERS),
        .IDX_W        (MGR_IDX_W)
    ) u_arbiter (
        .request     (manager_read_request | manager_write_request),
        .last_grant  (last_grant_q),
        .grant       (arb_grant),
        .grant_index (arb_index),
        .grant_valid (arb_valid)
    );

    // Write wins when a manager raises read and write together.
    always_comb begin
        sel_address = '0;
        sel_wdata   = '0;
        sel_strobe  = '0;
        sel_write   = 1'b0;
        for (int unsigned m = 0; m < NUM_MANAGERS; m++) begin
            if (arb_grant[m]) begin
                sel_address = manager_rw_address[32*m +: 32];
                sel_wdata   = manager_write_data[32*m +: 32];
                sel_strobe  = manager_write_strobe[4*m +: 4];
                sel_write   = manager_write_request[m];
            end
        end
    end

    always_comb begin
        dec_hit   = 1'b0;
        dec_index = '0;
        for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
            if (!dec_hit && region_hit(sel_address, device_start_address[32*d +: 32],
                                       device_region_size[32*d +: 32])) begin
                dec_hit   = 1'b1;
                dec_index = DEV_IDX_W'(d);
            end
        end
    end

    always_comb begin
        dev_resp  = 1'b0;
        dev_rdata = '0;
        for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
            if (dev_index_q == DEV_IDX_W'(d)) begin
                dev_resp  = is_write_q ? device_write_response[d] : device_read_response[d];
                dev_rdata = device_read_data[32*d +: 32];
            end
        end
    end

`ifdef RVSTEEL_BUS_TIMEOUT_EN
    logic [31:0] tmo_count_q, tmo_count_d;

    assign tmo_expired = (tmo_count_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_count_d = tmo_count_q;
        if (state_q != ST_ACTIVE)
            tmo_count_d = '0;
        else if (!tmo_expired)
            tmo_count_d = tmo_count_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) tmo_count_q <= '0;
        else       tmo_count_q <= tmo_count_d;
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grantee_d    = grantee_q;
        dev_index_d  = dev_index_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        strobe_d     = strobe_q;
        is_write_d   = is_write_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grantee_d   = arb_index;
                    address_d   = sel_address;
                    wdata_d     = sel_wdata;
                    strobe_d    = sel_strobe;
                    is_write_d  = sel_write;
                    dev_index_d = dec_index;
                    state_d     = dec_hit ? ST_ACTIVE : ST_FAULT;
                end
            end
            ST_ACTIVE: begin
                // A response in the expiry cycle completes normally.
                if (dev_resp) begin
                    last_grant_d = grantee_q;
                    state_d      = ST_IDLE;
                end else if (tmo_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                // Advancing the pointer keeps a repeatedly faulting manager from starving others.
                last_grant_d = grantee_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= '0;
            grantee_q    <= '0;
            dev_index_q  <= '0;
            address_q    <= '0;
            wdata_q      <= '0;
            strobe_q     <= '0;
            is_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grantee_q    <= grantee_d;
            dev_index_q  <= dev_index_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            strobe_q     <= strobe_d;
            is_write_q   <= is_write_d;
        end
    end

    assign device_rw_address   = address_q;
    assign device_write_data   = wdata_q;
    assign device_write_strobe = strobe_q;

    always_comb begin
        device_read_request  = '0;
        device_write_request = '0;
        for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
            if (state_q == ST_ACTIVE && dev_index_q == DEV_IDX_W'(d)) begin
                device_read_request[d]  = !is_write_q;
                device_write_request[d] = is_write_q;
            end
        end
    end

    always_comb begin
        manager_read_data      = '0;
        manager_read_response  = '0;
        manager_write_response = '0;
        manager_access_fault   = '0;
        for (int unsigned m = 0; m < NUM_MANAGERS; m++) begin
            if (grantee_q == MGR_IDX_W'(m)) begin
                if (state_q == ST_ACTIVE && dev_resp) begin
                    manager_read_response[m]  = !is_write_q;
                    manager_write_response[m] = is_write_q;
                    if (!is_write_q)
                        manager_read_data[32*m +: 32] = dev_rdata;
                end else if (state_q == ST_FAULT) begin
                    manager_read_response[m]  = !is_write_q;
                    manager_write_response[m] = is_write_q;
                    manager_access_fault[m]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvsteel_mm_bus.sv
// Directed self-checking bench for rvsteel_mm_bus: RAM at 0x0 (4 KiB), UART at 0x8000_0000 (256 B).
module tb_rvsteel_mm_bus;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] manager_rw_address;
    logic [63:0] manager_read_data;
    logic [1:0]  manager_read_request;
    logic [1:0]  manager_read_response;
    logic [63:0] manager_write_data;
    logic [7:0]  manager_write_strobe;
    logic [1:0]  manager_write_request;
    logic [1:0]  manager_write_response;
    logic [1:0]  manager_access_fault;
    logic [31:0] device_rw_address;
    logic [63:0] device_read_data;
    logic [1:0]  device_read_request;
    logic [1:0]  device_read_response;
    logic [31:0] device_write_data;
    logic [3:0]  device_write_strobe;
    logic [1:0]  device_write_request;
    logic [1:0]  device_write_response;
    logic [63:0] device_start_address;
    logic [63:0] device_region_size;

    int errors = 0;
    int checks = 0;

    rvsteel_mm_bus #(
        .NUM_MANAGERS   (2),
        .NUM_DEVICES    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .manager_rw_address     (manager_rw_address),
        .manager_read_data      (manager_read_data),
        .manager_read_request   (manager_read_request),
        .manager_read_response  (manager_read_response),
        .manager_write_data     (manager_write_data),
        .manager_write_strobe   (manager_write_strobe),
        .manager_write_request  (manager_write_request),
        .manager_write_response (manager_write_response),
        .manager_access_fault   (manager_access_fault),
        .device_rw_address      (device_rw_address),
        .device_read_data       (device_read_data),
        .device_read_request    (device_read_request),
        .device_read_response   (device_read_response),
        .device_write_data      (device_write_data),
        .device_write_strobe    (device_write_strobe),
        .device_write_request   (device_write_request),
        .device_write_response  (device_write_response),
        .device_start_address   (device_start_address),
        .device_region_size     (device_region_size)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        @(negedge clock);
        checks++; if (manager_read_response !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b expected 00", manager_read_response); end
        checks++; if (manager_write_response !== 2'b00) begin errors++; $display("FAIL reset_wresp: got %b expected 00", manager_write_response); end
        checks++; if (manager_access_fault !== 2'b00) begin errors++; $display("FAIL reset_fault: got %b expected 00", manager_access_fault); end
        checks++; if ((device_read_request | device_write_request) !== 2'b00) begin errors++; $display("FAIL reset_devreq: got r=%b w=%b expected 00", device_read_request, device_write_request); end
        checks++; if ({device_rw_address, device_write_data, device_write_strobe} !== 68'h0) begin errors++; $display("FAIL reset_devbus: got addr=%h data=%h strb=%b expected 0", device_rw_address, device_write_data, device_write_strobe); end
        checks++; if (manager_read_data !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", manager_read_data); end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_read();
        cyc();
        manager_rw_address[31:0] = 32'h0000_0010;
        manager_read_request[0]  = 1'b1;
        @(negedge clock);
        checks++; if (device_read_request !== 2'b00) begin errors++; $display("FAIL read_t0_devreq: got %b expected 00", device_read_request); end
        cyc();
        @(negedge clock);
        checks++; if (device_read_request !== 2'b01) begin errors++; $display("FAIL read_t1_devreq: got %b expected 01", device_read_request); end
        checks++; if (device_rw_address !== 32'h0000_0010) begin errors++; $display("FAIL read_t1_addr: got %h expected 00000010", device_rw_address); end
        checks++; if (manager_read_response !== 2'b00) begin errors++; $display("FAIL read_t1_rresp: got %b expected 00", manager_read_response); end
        cyc();
        device_read_data[31:0]  = 32'hDEAD_BEEF;
        device_read_response[0] = 1'b1;
        @(negedge clock);
        checks++; if (manager_read_response !== 2'b01) begin errors++; $display("FAIL read_t2_rresp: got %b expected 01", manager_read_response); end
        checks++; if (manager_read_data !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL read_t2_rdata: got %h expected 00000000deadbeef", manager_read_data); end
        checks++; if (manager_access_fault !== 2'b00) begin errors++; $display("FAIL read_t2_fault: got %b expected 00", manager_access_fault); end
        cyc();
        manager_read_request[0] = 1'b0;
        device_read_response[0] = 1'b0;
        @(negedge clock);
        checks++; if ({manager_read_response, device_read_request} !== 4'b0000) begin errors++; $display("FAIL read_t3_idle: got rresp=%b devreq=%b expected 00/00", manager_read_response, device_read_request); end
    endtask

    task automatic test_uart_write();
        cyc();
        manager_rw_address[63:32]  = 32'h8000_0004;
        manager_write_data[63:32]  = 32'h0000_0041;
        manager_write_strobe[7:4]  = 4'b0001;
        manager_write_request[1]   = 1'b1;
        device_write_response[1]   = 1'b1;
        @(negedge clock);
        checks++; if (manager_write_response !== 2'b00) begin errors++; $display("FAIL uart_idle_resp_ignored: got %b expected 00", manager_write_response); end
        cyc();
        device_write_response = 2'b01;
        @(negedge clock);
        checks++; if (device_write_request !== 2'b10) begin errors++; $display("FAIL uart_devreq: got %b expected 10", device_write_request); end
        checks++; if (device_write_data !== 32'h41 || device_write_strobe !== 4'b0001) begin errors++; $display("FAIL uart_wdata: got %h/%b expected 00000041/0001", device_write_data, device_write_strobe); end
        checks++; if (device_rw_address !== 32'h8000_0004) begin errors++; $display("FAIL uart_addr: got %h expected 80000004", device_rw_address); end
        checks++; if (manager_write_response !== 2'b00) begin errors++; $display("FAIL uart_stray_resp_ignored: got %b expected 00", manager_write_response); end
        cyc();
        device_write_response = 2'b00;
        @(negedge clock);
        checks++; if (device_write_request !== 2'b10) begin errors++; $display("FAIL uart_held: got %b expected 10", device_write_request); end
        cyc();
        device_write_response[1] = 1'b1;
        @(negedge clock);
        checks++; if (manager_write_response !== 2'b10 || manager_access_fault !== 2'b00) begin errors++; $display("FAIL uart_resp: got resp=%b fault=%b expected 10/00", manager_write_response, manager_access_fault); end
        cyc();
        device_write_response    = 2'b00;
        manager_write_request[1] = 1'b0;
        @(negedge clock);
        checks++; if (device_write_request !== 2'b00) begin errors++; $display("FAIL uart_done: got %b expected 00", device_write_request); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          wait_cnt;
        cyc();
        manager_rw_address   = {32'h0000_0104, 32'h0000_0100};
        manager_write_data   = {32'h0000_00B1, 32'h0000_00A0};
        manager_write_strobe = 8'hFF;
        manager_write_request = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_data = (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
            exp_resp = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_cnt = 0;
            @(negedge clock);
            while (device_write_request[0] !== 1'b1 && wait_cnt < 10) begin
                @(negedge clock);
                wait_cnt++;
            end
            checks++; if (wait_cnt >= 10) begin errors++; $display("FAIL rr_wait[%0d]: got no device request expected one within 10 cycles", k); end
            checks++; if (device_write_data !== exp_data) begin errors++; $display("FAIL rr_grant[%0d]: got data %h expected %h", k, device_write_data, exp_data); end
            device_write_response[0] = 1'b1;
            #1;
            checks++; if (manager_write_response !== exp_resp) begin errors++; $display("FAIL rr_resp[%0d]: got %b expected %b", k, manager_write_response, exp_resp); end
            cyc();
            device_write_response[0] = 1'b0;
        end
        manager_write_request = 2'b00;
        @(negedge clock);
        checks++; if (device_write_request !== 2'b00) begin errors++; $display("FAIL rr_done: got %b expected 00", device_write_request); end
    endtask

    task automatic test_fault();
        device_read_data = {32'h1111_2222, 32'h3333_4444};
        cyc();
        manager_rw_address[31:0] = 32'h4000_0000;
        manager_read_request[0]  = 1'b1;
        @(negedge clock);
        checks++; if (manager_access_fault !== 2'b00) begin errors++; $display("FAIL fault_t0: got %b expected 00", manager_access_fault); end
        cyc();
        @(negedge clock);
        checks++; if (manager_read_response !== 2'b01 || manager_access_fault !== 2'b01) begin errors++; $display("FAIL fault_t1_pulse: got resp=%b fault=%b expected 01/01", manager_read_response, manager_access_fault); end
        checks++; if (manager_read_data !== 64'h0) begin errors++; $display("FAIL fault_t1_rdata: got %h expected 0", manager_read_data); end
        checks++; if ((device_read_request | device_write_request) !== 2'b00) begin errors++; $display("FAIL fault_t1_devreq: got r=%b w=%b expected 00", device_read_request, device_write_request); end
        cyc();
        manager_read_request[0] = 1'b0;
        @(negedge clock);
        checks++; if ({manager_read_response, manager_access_fault} !== 4'b0000) begin errors++; $display("FAIL fault_t2_idle: got resp=%b fault=%b expected 00/00", manager_read_response, manager_access_fault); end
        // RAM region boundary: 0x1000 is one past the end.
        cyc();
        manager_rw_address[63:32] = 32'h0000_1000;
        manager_write_request[1]  = 1'b1;
        cyc();
        @(negedge clock);
        checks++; if (manager_write_response !== 2'b10 || manager_access_fault !== 2'b10) begin errors++; $display("FAIL fault_edge: got resp=%b fault=%b expected 10/10", manager_write_response, manager_access_fault); end
        cyc();
        manager_write_request[1] = 1'b0;
        // Last byte of RAM decodes to device 0.
        cyc();
        manager_rw_address[63:32] = 32'h0000_0FFF;
        manager_read_request[1]   = 1'b1;
        cyc();
        @(negedge clock);
        checks++; if (device_read_request !== 2'b01 || manager_access_fault !== 2'b00) begin errors++; $display("FAIL decode_edge: got devreq=%b fault=%b expected 01/00", device_read_request, manager_access_fault); end
        device_read_response[0] = 1'b1;
        #1;
        checks++; if (manager_read_response !== 2'b10 || manager_read_data !== 64'h3333_4444_0000_0000) begin errors++; $display("FAIL decode_edge_resp: got resp=%b data=%h expected 10/3333444400000000", manager_read_response, manager_read_data); end
        cyc();
        device_read_response[0] = 1'b0;
        manager_read_request[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        cyc();
        manager_rw_address[31:0] = 32'h0000_0020;
        manager_read_request[0]  = 1'b1;
        cyc();
        @(negedge clock);
        checks++; if (device_read_request !== 2'b01) begin errors++; $display("FAIL rstmid_active: got %b expected 01", device_read_request); end
        cyc();
        reset = 1'b1;
        manager_read_request[0] = 1'b0;
        cyc();
        reset = 1'b0;
        checks++; if ({device_read_request, device_write_request, manager_read_response, manager_write_response, manager_access_fault} !== 10'h0 || device_rw_address !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got devreq=%b/%b resp=%b/%b fault=%b addr=%h expected all 0", device_read_request, device_write_request, manager_read_response, manager_write_response, manager_access_fault, device_rw_address); end
        manager_rw_address   = {32'h8000_0010, 32'h0000_0030};
        device_read_data     = {32'h0000_0055, 32'h0000_0066};
        manager_read_request = 2'b11;
        cyc();
        @(negedge clock);
        checks++; if (device_read_request !== 2'b10) begin errors++; $display("FAIL rstmid_first_grant: got %b expected 10", device_read_request); end
        device_read_response[1] = 1'b1;
        #1;
        checks++; if (manager_read_response !== 2'b10 || manager_read_data !== 64'h0000_0055_0000_0000) begin errors++; $display("FAIL rstmid_m1_resp: got resp=%b data=%h expected 10/0000005500000000", manager_read_response, manager_read_data); end
        cyc();
        device_read_response[1] = 1'b0;
        manager_read_request[1] = 1'b0;
        cyc();
        @(negedge clock);
        checks++; if (device_read_request !== 2'b01) begin errors++; $display("FAIL rstmid_second_grant: got %b expected 01", device_read_request); end
        device_read_response[0] = 1'b1;
        #1;
        checks++; if (manager_read_response !== 2'b01 || manager_read_data !== 64'h0000_0000_0000_0066) begin errors++; $display("FAIL rstmid_m0_resp: got resp=%b data=%h expected 01/0000000000000066", manager_read_response, manager_read_data); end
        cyc();
        device_read_response[0] = 1'b0;
        manager_read_request[0] = 1'b0;
    endtask

`ifdef RVSTEEL_BUS_TIMEOUT_EN
    task automatic test_timeout();
        cyc();
        manager_rw_address[31:0] = 32'h0000_0040;
        manager_read_request[0]  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            @(negedge clock);
            checks++; if (device_read_request !== 2'b01 || manager_access_fault !== 2'b00) begin errors++; $display("FAIL timeout_active[%0d]: got devreq=%b fault=%b expected 01/00", k, device_read_request, manager_access_fault); end
        end
        cyc();
        @(negedge clock);
        checks++; if (manager_read_response !== 2'b01 || manager_access_fault !== 2'b01 || device_read_request !== 2'b00) begin errors++; $display("FAIL timeout_fault: got resp=%b fault=%b devreq=%b expected 01/01/00", manager_read_response, manager_access_fault, device_read_request); end
        cyc();
        manager_read_request[0] = 1'b0;
        @(negedge clock);
        checks++; if ({manager_read_response, manager_access_fault, device_read_request} !== 6'b0) begin errors++; $display("FAIL timeout_idle: got resp=%b fault=%b devreq=%b expected 0", manager_read_response, manager_access_fault, device_read_request); end
    endtask
`endif

    initial begin
        reset                 = 1'b1;
        manager_rw_address    = '0;
        manager_read_request  = '0;
        manager_write_data    = '0;
        manager_write_strobe  = '0;
        manager_write_request = '0;
        device_read_data      = '0;
        device_read_response  = '0;
        device_write_response = '0;
        device_start_address  = {32'h8000_0000, 32'h0000_0000};
        device_region_size    = {32'h0000_0100, 32'h0000_1000};

        test_reset();
        test_read();
        test_uart_write();
        test_back_to_back();
        test_fault();
        test_reset_mid();
`ifdef RVSTEEL_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvsteel_mm_bus.md
Name: rvsteel_mm_bus

Overview:
Parametrised multi-manager system bus, successor to the single-manager SoC interconnect. Arbitrates NUM_MANAGERS managers (CPU core, DMA, debug) onto NUM_DEVICES memory-mapped devices. Uses round-robin grant, per-transaction address decode against start/size regions, and an access-fault response for unmapped addresses. Sits between the manager ports and the RAM/UART/peripheral devices in the SoC top.

Parameters:
NUM_MANAGERS, 2, number of manager ports (1..8)
NUM_DEVICES, 2, number of device ports (1..16)
TIMEOUT_CYCLES, 255, cycles an ACTIVE transaction waits for a device response before fault (only with timeout feature)

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
manager_rw_address  input  NUM_MANAGERS*32  per-manager address, slice m at [32*m +: 32]
manager_read_data  output  NUM_MANAGERS*32  per-manager read data
manager_read_request  input  NUM_MANAGERS  read request, held until response
manager_read_response  output  NUM_MANAGERS  one-cycle read completion pulse
manager_write_data  input  NUM_MANAGERS*32  write data
manager_write_strobe  input  NUM_MANAGERS*4  byte strobes
manager_write_request  input  NUM_MANAGERS  write request, held until response
manager_write_response  output  NUM_MANAGERS  one-cycle write completion pulse
manager_access_fault  output  NUM_MANAGERS  pulses with response when the access faulted
device_rw_address  output  32  registered address of the granted transaction
device_read_data  input  NUM_DEVICES*32  per-device read data
device_read_request  output  NUM_DEVICES  read request to the selected device
device_read_response  input  NUM_DEVICES  device read completion
device_write_data  output  32  registered write data
device_write_strobe  output  4  registered strobes
device_write_request  output  NUM_DEVICES  write request to the selected device
device_write_response  input  NUM_DEVICES  device write completion
device_start_address  input  NUM_DEVICES*32  region base per device
device_region_size  input  NUM_DEVICES*32  region size per device, power of 2

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: FSM goes to IDLE, round-robin pointer is 0, and all outputs are 0. A reset mid-transaction aborts it silently with no response.
- FSM states are IDLE, ACTIVE and FAULT.
- IDLE: when any manager request is high, grant the first requester at or after (last_grant+1) mod NUM_MANAGERS.
  - Latch the grantee's address, write data, strobes, direction and decoded device index.
  - If the decode hits, go to ACTIVE; otherwise go to FAULT.
  - If a manager raises read and write together, the write is serviced and the read is ignored.
- Decode: device d hits when (addr - start_d) < size_d, unsigned 32-bit. The lowest index wins on overlap.
- ACTIVE: hold device_{read,write}_request[d] high. When response[d] is seen:
  - route the response combinationally to the grantee in the same cycle;
  - for reads, drive manager_read_data = device_read_data[d];
  - set last_grant to the grantee and go to IDLE.
- FAULT: for one cycle, pulse the grantee's response and manager_access_fault with read_data 0, then go to IDLE.
- Latency: request seen in cycle t; device request asserted at t+1; manager response in the cycle the device responds. A faulted access responds at t+1. There is one IDLE turnaround cycle between transactions.
- Managers drop their request in the cycle after the response. A request still high in IDLE is a new request.
- Non-granted managers see response=0 and read_data=0.
- Device responses from non-selected devices, or arriving in IDLE, are ignored.

Optional Feature:
RVSTEEL_BUS_TIMEOUT_EN
- Defined: an ACTIVE cycle counter starts at 0 on entry. If it reaches TIMEOUT_CYCLES with no response, drop the device request and go to FAULT. A response arriving in the same cycle as expiry wins, and no fault is raised.
- Undefined: no counter; ACTIVE waits indefinitely.

Decomposition:
- Package rvsteel_bus_pkg holds the FSM state encoding (IDLE=0, ACTIVE=1, FAULT=2) and the constant for the default timeout.
- One natural sub-module, rvsteel_rr_arbiter: a NUM_MANAGERS-wide round-robin grant from a request vector and last_grant, producing a one-hot grant plus index.
- Decode, latching and the FSM stay in rvsteel_mm_bus.

Test Plan:
- M0 read at 0x0000_0010, RAM responds 2 cycles after request with 0xDEADBEEF -> M0 read_response pulse with data 0xDEADBEEF, no fault, M1 outputs 0.
- M0 and M1 write requests held continuously to the RAM for 4 transactions -> grants alternate M0, M1, M0, M1.
- M1 write 0x8000_0004, strobe 4'b0001, data 0x41 -> device_write_request[1] high with device_write_data 0x41 and strobe 0001 until UART responds.
- M0 read of unmapped 0x4000_0000 -> at t+1, read_response[0] and access_fault[0] pulse with data 0, and no device request is raised.
- With RVSTEEL_BUS_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, the device never responds -> fault pulse after 8 ACTIVE cycles and the bus returns to IDLE.
- Reset asserted while ACTIVE -> next cycle all outputs are 0, and a subsequent M1 request is granted first or second per a pointer value of 0.
